// File: rtl/dsp48a1_op_sequencer.sv
// Command sequencer for one DSP48A1 slice: issues ops with hazard and credit checks,
// tracks them through the 4-stage slice pipeline and buffers P/CARRYOUT in a result FIFO.
module dsp48a1_op_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [17:0] cmd_d,
    input  logic [47:0] cmd_c,
    output logic [17:0] dsp_A,
    output logic [17:0] dsp_B,
    output logic [17:0] dsp_D,
    output logic [47:0] dsp_C,
    output logic [7:0]  dsp_OPMODE,
    output logic        dsp_CARRYIN,
    output logic        dsp_CE1,
    output logic        dsp_CEC,
    output logic        dsp_CE2,
    output logic        dsp_CEM,
    output logic        dsp_CEP,
    output logic        dsp_RST,
    input  logic [47:0] dsp_P,
    input  logic        dsp_CARRYOUT,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_p,
    output logic        res_carry,
    output logic        op_err
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 4) + 1;

    typedef enum logic [2:0] {
        OP_MUL        = 3'd0,
        OP_PREADD_MUL = 3'd1,
        OP_PRESUB_MUL = 3'd2,
        OP_MUL_ADD_C  = 3'd3,
        OP_MAC_ACC    = 3'd4,
        OP_C_SUB_MUL  = 3'd5
    } op_e;

    logic          rst_q, rst_d;
    logic [4:1]    v_q, v_d;
    logic [7:0]    last_opmode_q, last_opmode_d;
    logic          op_err_q, op_err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [48:0]   mem_q [FIFO_DEPTH];

    logic [7:0]    cmd_opmode;
    logic          uses_c;
    logic          bad_op;
    logic [CW-1:0] inflight;
    logic          credit_ok;
    logic          hazard_ok;
    logic          issue;
    logic          push;
    logic          pop;

    // Op decode. NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        cmd_opmode = 8'h01;
        uses_c     = 1'b0;
        bad_op     = 1'b0;
        case (cmd_op)
            OP_MUL:        cmd_opmode = 8'h01;
            OP_PREADD_MUL: cmd_opmode = 8'h11;
            OP_PRESUB_MUL: cmd_opmode = 8'h51;
            OP_MUL_ADD_C: begin
                cmd_opmode = 8'h0D;
                uses_c     = 1'b1;
            end
            OP_MAC_ACC:    cmd_opmode = 8'h09;
            OP_C_SUB_MUL: begin
                cmd_opmode = 8'h8D;
                uses_c     = 1'b1;
            end
            default:       bad_op = 1'b1;
        endcase
    end

    // The slice has one OPMODE and one C register, so in-flight ops must share them.
    always_comb begin
        inflight  = CW'(v_q[1]) + CW'(v_q[2]) + CW'(v_q[3]) + CW'(v_q[4]);
        credit_ok = (count_q + inflight) < CW'(FIFO_DEPTH);
        hazard_ok = (v_q == 4'b0000) || (!uses_c && (cmd_opmode == last_opmode_q));
        cmd_ready = !rst_q && credit_ok && hazard_ok;
        issue     = cmd_valid && cmd_ready;
        push      = v_q[4];
        pop       = res_valid && res_ready;
    end

    always_comb begin
        rst_d         = 1'b0;
        v_d           = {v_q[3:1], issue};
        last_opmode_d = issue ? cmd_opmode : last_opmode_q;
        op_err_d      = op_err_q || (issue && bad_op);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q         <= 1'b1;
            v_q           <= '0;
            last_opmode_q <= 8'h00;
            op_err_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            rst_q         <= rst_d;
            v_q           <= v_d;
            last_opmode_q <= last_opmode_d;
            op_err_q      <= op_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is carried by count_q alone,
    // so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dsp_CARRYOUT, dsp_P};
        end
    end

    assign dsp_A       = cmd_a;
    assign dsp_B       = cmd_b;
    assign dsp_D       = cmd_d;
    assign dsp_C       = cmd_c;
    assign dsp_OPMODE  = issue ? cmd_opmode : last_opmode_q;
    assign dsp_CARRYIN = 1'b0;
    assign dsp_CE1     = issue;
    assign dsp_CEC     = issue && uses_c;
    assign dsp_CE2     = v_q[1];
    assign dsp_CEM     = v_q[2];
    assign dsp_CEP     = v_q[3];
    assign dsp_RST     = rst_q;

    assign res_valid              = (count_q != '0);
    assign {res_carry, res_p}     = mem_q[rd_ptr_q];
    assign op_err                 = op_err_q;

endmodule
